// File: rtl/parking_gate_ctrl.sv
// Barrier-gate controller for one parking entrance or exit.
// The controller filters the raw loop sensors and sequences the barrier motor.
// It emits one count event for each car that passes over the barrier loop.
module parking_gate_ctrl #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned OPEN_CYCLES  = 50_000_000,
  parameter int unsigned CLOSE_CYCLES = 50_000_000,
  parameter int unsigned PASS_TIMEOUT = 500_000_000,
  parameter int unsigned EVENT_HOLD   = 1_000_000,
  parameter int unsigned TIMER_W      = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_car_present,
  input  logic i_car_passed,
  input  logic i_space_avail,
  output logic o_motor_up,
  output logic o_motor_down,
  output logic o_gate_open,
  output logic o_denied,
  output logic o_count_event,
  output logic o_timeout_flag
);

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0]     DbLast    = DbW'(DEBOUNCE - 1);
  localparam logic [TIMER_W-1:0] OpenLast  = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CloseLast = TIMER_W'(CLOSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PassLast  = TIMER_W'(PASS_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] EvLast    = TIMER_W'(EVENT_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOpening,
    StWaitPass,
    StClosing
  } state_e;

  // Sensor synchronizers and stability filters
  logic           r_pres_s1, r_pres_s2, r_pres_f;
  logic           r_pass_s1, r_pass_s2, r_pass_f;
  logic [DbW-1:0] r_pres_cnt, r_pass_cnt;
  logic           r_pass_prev;
  logic           w_pres_diff, w_pass_diff;
  logic           w_pres_flip, w_pass_flip;
  logic           w_pass_rise;

  // Sequencer state
  state_e               r_state, w_state_d;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_seen;
  logic                 w_timer_clr;
  logic                 w_seen_clr;
  logic                 w_ev_start;
  logic                 w_timeout;

  // Registered outputs
  logic                 r_denied;
  logic                 r_timeout;
  logic                 r_event;
  logic [TIMER_W-1:0]   r_ev_timer;

  // Filter decisions: a flip happens on the DEBOUNCE-th consecutive differing sample
  always_comb begin
    w_pres_diff = r_pres_s2 ^ r_pres_f;
    w_pass_diff = r_pass_s2 ^ r_pass_f;
    w_pres_flip = w_pres_diff && (r_pres_cnt == DbLast);
    w_pass_flip = w_pass_diff && (r_pass_cnt == DbLast);
    w_pass_rise = r_pass_f && !r_pass_prev;
  end

  // Two-flop synchronizers, debounce counters and filtered values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pres_s1   <= 1'b0;
      r_pres_s2   <= 1'b0;
      r_pres_f    <= 1'b0;
      r_pres_cnt  <= '0;
      r_pass_s1   <= 1'b0;
      r_pass_s2   <= 1'b0;
      r_pass_f    <= 1'b0;
      r_pass_cnt  <= '0;
      r_pass_prev <= 1'b0;
    end else begin
      r_pres_s1   <= i_car_present;
      r_pres_s2   <= r_pres_s1;
      r_pass_s1   <= i_car_passed;
      r_pass_s2   <= r_pass_s1;
      r_pass_prev <= r_pass_f;

      if (!w_pres_diff) begin
        r_pres_cnt <= '0;
      end else if (w_pres_flip) begin
        r_pres_cnt <= '0;
        r_pres_f   <= r_pres_s2;
      end else begin
        r_pres_cnt <= r_pres_cnt + 1'b1;
      end

      if (!w_pass_diff) begin
        r_pass_cnt <= '0;
      end else if (w_pass_flip) begin
        r_pass_cnt <= '0;
        r_pass_f   <= r_pass_s2;
      end else begin
        r_pass_cnt <= r_pass_cnt + 1'b1;
      end
    end
  end

  // Next-state logic and the single-cycle control strobes
  always_comb begin
    w_state_d   = r_state;
    w_timer_clr = 1'b0;
    w_seen_clr  = 1'b0;
    w_ev_start  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_pres_f && i_space_avail) begin
          w_state_d   = StOpening;
          w_timer_clr = 1'b1;
          w_seen_clr  = 1'b1;
        end
      end
      StOpening: begin
        // Once raising, the gate is committed even if space_avail drops
        if (r_timer == OpenLast) begin
          w_state_d   = StWaitPass;
          w_timer_clr = 1'b1;
        end
      end
      StWaitPass: begin
        if (w_pass_rise && !r_seen) begin
          w_ev_start = 1'b1;
        end
        if (r_seen && !r_pass_f && !r_pres_f) begin
          w_state_d   = StClosing;
          w_timer_clr = 1'b1;
        end else if (!r_seen && (r_timer == PassLast)) begin
          w_state_d   = StClosing;
          w_timer_clr = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      StClosing: begin
        // Safety reversal; passed_seen is kept so the car is not counted twice
        if (r_pass_f || r_pres_f) begin
          w_state_d   = StOpening;
          w_timer_clr = 1'b1;
        end else if (r_timer == CloseLast) begin
          w_state_d   = StIdle;
          w_timer_clr = 1'b1;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_timer_clr = 1'b1;
      end
    endcase
  end

  // State register, saturating state timer and the passed_seen flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_timer_clr || (r_state == StIdle)) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_seen_clr) begin
        r_seen <= 1'b0;
      end else if (w_ev_start) begin
        r_seen <= 1'b1;
      end
    end
  end

  // Registered status outputs and the count_event hold timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_denied   <= 1'b0;
      r_timeout  <= 1'b0;
      r_event    <= 1'b0;
      r_ev_timer <= '0;
    end else begin
      r_denied  <= (r_state == StIdle) && r_pres_f && !i_space_avail;
      r_timeout <= w_timeout;
      if (w_ev_start) begin
        // A fresh pass restarts the hold even if the previous pulse is still high
        r_event    <= 1'b1;
        r_ev_timer <= '0;
      end else if (r_event) begin
        if (r_ev_timer == EvLast) begin
          r_event    <= 1'b0;
          r_ev_timer <= '0;
        end else begin
          r_ev_timer <= r_ev_timer + 1'b1;
        end
      end
    end
  end

  assign o_motor_up     = (r_state == StOpening);
  assign o_motor_down   = (r_state == StClosing);
  assign o_gate_open    = (r_state == StWaitPass);
  assign o_denied       = r_denied;
  assign o_count_event  = r_event;
  assign o_timeout_flag = r_timeout;

endmodule
